// File: rtl/shift_arbiter.sv
// Two requesters share one barrel shifter via round-robin grant; done after 2 cycles (1 for illegal ops).
// Requests are level-held until done; SHIFT_ARB_ROR_EN enables the rotate mode.
module shift_arbiter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   in0,
  input  logic [SHAMT_W-1:0] shamt0,
  input  logic [1:0]         mode0,
  output logic               done0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   in1,
  input  logic [SHAMT_W-1:0] shamt1,
  input  logic [1:0]         mode1,
  output logic               done1,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state, state_d;
  logic               rr_ptr;
  logic               owner;
  logic [WIDTH-1:0]   op_x;
  logic [SHAMT_W-1:0] op_s;
  logic [1:0]         op_m;

  logic               grant;
  logic               gnt_sel;
  logic [1:0]         sel_mode;
  logic               sel_legal;

  function automatic logic is_legal(input logic [1:0] m);
`ifdef SHIFT_ARB_ROR_EN
    return m != 2'b11;
`else
    return m[1] == 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0]   x,
                                                input logic [SHAMT_W-1:0] s,
                                                input logic [1:0]         m);
`ifdef SHIFT_ARB_ROR_EN
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> s;
`endif
    do_shift = x;
    case (m)
      2'b00:   do_shift = x << s;
      2'b01:   do_shift = $signed(x) >>> s;
`ifdef SHIFT_ARB_ROR_EN
      2'b10:   do_shift = dbl[WIDTH-1:0];
`endif
      default: do_shift = x;
    endcase
  endfunction

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  always_comb begin
    grant     = req0 | req1;
    gnt_sel   = req1 & (~req0 | rr_ptr);
    sel_mode  = gnt_sel ? mode1 : mode0;
    sel_legal = is_legal(sel_mode);
    state_d   = state;
    case (state)
      IDLE:    if (grant) state_d = sel_legal ? EXEC : DONE;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      op_x   <= '0;
      op_s   <= '0;
      op_m   <= '0;
      result <= '0;
      err    <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          owner  <= gnt_sel;
          rr_ptr <= ~gnt_sel;
          op_x   <= gnt_sel ? in1 : in0;
          op_s   <= gnt_sel ? shamt1 : shamt0;
          op_m   <= sel_mode;
          if (!sel_legal) begin
            // Illegal ops skip the shifter and report at once with a zero result.
            result <= '0;
            err    <= 1'b1;
            done0  <= ~gnt_sel;
            done1  <= gnt_sel;
          end
        end
        EXEC: begin
          result <= do_shift(op_x, op_s, op_m);
          err    <= 1'b0;
          done0  <= ~owner;
          done1  <= owner;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: latency, arithmetic, arbitration, illegal ops, reset abort.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] in0, in1;
  logic [3:0]  shamt0, shamt1;
  logic [1:0]  mode0, mode1;
  logic        done0, done1, err, busy;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .in0(in0), .shamt0(shamt0), .mode0(mode0), .done0(done0),
    .req1(req1), .in1(in1), .shamt1(shamt1), .mode1(mode1), .done1(done1),
    .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from an idle arbiter and checks the full done handshake.
  task automatic run_op(input string tag, input int who, input logic [15:0] x,
                        input logic [3:0] s, input logic [1:0] m,
                        input logic [15:0] exp_res, input logic exp_err);
    if (who == 0) begin req0 = 1'b1; in0 = x; shamt0 = s; mode0 = m; end
    else          begin req1 = 1'b1; in1 = x; shamt1 = s; mode1 = m; end
    step();
    chk({tag, ".busy1"}, busy, 1);
    if (!exp_err) begin
      chk({tag, ".early"}, {done0, done1}, 2'b00);
      step();
    end
    chk({tag, ".done0"}, done0, (who == 0));
    chk({tag, ".done1"}, done1, (who == 1));
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".err"}, err, exp_err);
    req0 = 1'b0; req1 = 1'b0;
    in0 = 16'hDEAD; in1 = 16'hBEEF;
    step();
    chk({tag, ".pulse"}, {done0, done1}, 2'b00);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    in0 = '0; in1 = '0; shamt0 = '0; shamt1 = '0; mode0 = '0; mode1 = '0;
    step(); step();
    chk("rst.done", {done0, done1}, 2'b00);
    chk("rst.result", result, 16'h0000);
    chk("rst.err", err, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    step();

    run_op("sll", 0, 16'h00F1, 4'd4, 2'b00, 16'h0F10, 1'b0);
    run_op("sra_neg", 1, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0);
    run_op("sra_pos", 1, 16'h7FFF, 4'd3, 2'b01, 16'h0FFF, 1'b0);
    run_op("sll_r1", 1, 16'h8001, 4'd1, 2'b00, 16'h0002, 1'b0);
`ifdef SHIFT_ARB_ROR_EN
    run_op("ror", 0, 16'h1234, 4'd4, 2'b10, 16'h4123, 1'b0);
    run_op("ror_s0", 0, 16'hA5C3, 4'd0, 2'b10, 16'hA5C3, 1'b0);
`else
    run_op("ror_ill", 0, 16'h1234, 4'd4, 2'b10, 16'h0000, 1'b1);
`endif
    run_op("ill11_r0", 0, 16'h1234, 4'd4, 2'b11, 16'h0000, 1'b1);
    run_op("ill11_r1", 1, 16'hFFFF, 4'd1, 2'b11, 16'h0000, 1'b1);
    run_op("sll_s0", 0, 16'hA5C3, 4'd0, 2'b00, 16'hA5C3, 1'b0);
    run_op("sra_s0", 1, 16'hA5C3, 4'd0, 2'b01, 16'hA5C3, 1'b0);

    // Both requesters held after reset: strict alternation starting with requester 0.
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; in0 = 16'h00F1; shamt0 = 4'd4;  mode0 = 2'b00;
    req1 = 1'b1; in1 = 16'h8000; shamt1 = 4'd15; mode1 = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("alt.d0.%0d", k), done0, (k == 2 || k == 8));
      chk($sformatf("alt.d1.%0d", k), done1, (k == 5 || k == 11));
      if (k == 2 || k == 8)  chk($sformatf("alt.r0.%0d", k), result, 16'h0F10);
      if (k == 5 || k == 11) chk($sformatf("alt.r1.%0d", k), result, 16'hFFFF);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    chk("alt.end", busy, 0);

    // Reset during EXEC discards the op; the held request is re-granted.
    req0 = 1'b1; in0 = 16'h0003; shamt0 = 4'd2; mode0 = 2'b00;
    step();
    chk("abort.exec", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.nodone", done0, 0);
    chk("abort.busy", busy, 0);
    chk("abort.res", result, 16'h0000);
    step();
    chk("abort.regrant", busy, 1);
    chk("abort.early", done0, 0);
    step();
    chk("abort.done0", done0, 1);
    chk("abort.result", result, 16'h000C);
    req0 = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
